if_id_buffer: RTL

- Fetch/decode boundary register between the IF stage and the ID stage.
- Captures each fetched (pc, instruction) pair and presents it to ID with a valid flag.
- Two entries: a main slot plus one skid slot, so an ID stall never feeds combinationally into the fetch freeze (if_bubble).
- Branch/exception flush discards everything in flight.

---
 rtl/if_id_buffer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/if_id_buffer.sv
// IF/ID boundary register: main slot plus one skid slot so that an ID stall reaches IF only through the registered if_bubble.
// Optional fetch-address-error tagging is enabled by defining IF_ID_FETCH_EXC_EN.
module if_id_buffer #(
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] RESET_PC = 32'h80000000,
    parameter logic [DATA_W-1:0] NOP_INS  = 32'h00000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] if_pc,
    input  logic [DATA_W-1:0] if_ins,
    input  logic              if_valid,
    output logic              if_bubble,
    input  logic              flush,
    input  logic              id_stall,
    output logic [DATA_W-1:0] id_pc,
    output logic [DATA_W-1:0] id_ins,
`ifdef IF_ID_FETCH_EXC_EN
    output logic              id_exc_adel,
`endif
    output logic              id_valid
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_pc_q, main_pc_d;
    logic [DATA_W-1:0] main_ins_q, main_ins_d;
    logic [DATA_W-1:0] skid_pc_q, skid_pc_d;
    logic [DATA_W-1:0] skid_ins_q, skid_ins_d;
    logic              valid_q, valid_d;
    logic              bubble_q, bubble_d;
    logic              push, pop;
    logic [DATA_W-1:0] in_ins;
`ifdef IF_ID_FETCH_EXC_EN
    logic              in_exc;
    logic              main_exc_q, main_exc_d;
    logic              skid_exc_q, skid_exc_d;
`endif

    assign push = if_valid & ~bubble_q & ~flush;
    assign pop  = valid_q & ~id_stall;

    // A misaligned fetch is kept as a harmless NOP carrying the exception flag.
`ifdef IF_ID_FETCH_EXC_EN
    assign in_exc = |if_pc[1:0];
    assign in_ins = in_exc ? NOP_INS : if_ins;
`else
    assign in_ins = if_ins;
`endif

    always_comb begin
        state_d    = state_q;
        main_pc_d  = main_pc_q;
        main_ins_d = main_ins_q;
        skid_pc_d  = skid_pc_q;
        skid_ins_d = skid_ins_q;
`ifdef IF_ID_FETCH_EXC_EN
        main_exc_d = main_exc_q;
        skid_exc_d = skid_exc_q;
`endif
        if (flush) begin
            state_d    = EMPTY;
            main_ins_d = NOP_INS;
`ifdef IF_ID_FETCH_EXC_EN
            main_exc_d = 1'b0;
            skid_exc_d = 1'b0;
`endif
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        main_pc_d  = if_pc;
                        main_ins_d = in_ins;
`ifdef IF_ID_FETCH_EXC_EN
                        main_exc_d = in_exc;
`endif
                        state_d    = ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_pc_d  = if_pc;
                        main_ins_d = in_ins;
`ifdef IF_ID_FETCH_EXC_EN
                        main_exc_d = in_exc;
`endif
                    end else if (push) begin
                        skid_pc_d  = if_pc;
                        skid_ins_d = in_ins;
`ifdef IF_ID_FETCH_EXC_EN
                        skid_exc_d = in_exc;
`endif
                        state_d    = FULL;
                    end else if (pop) begin
                        main_ins_d = NOP_INS;
`ifdef IF_ID_FETCH_EXC_EN
                        main_exc_d = 1'b0;
`endif
                        state_d    = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        main_pc_d  = skid_pc_q;
                        main_ins_d = skid_ins_q;
`ifdef IF_ID_FETCH_EXC_EN
                        main_exc_d = skid_exc_q;
                        skid_exc_d = 1'b0;
`endif
                        state_d    = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        // Outputs are decoded from the next state so they come straight off flops.
        valid_d  = (state_d != EMPTY);
        bubble_d = (state_d == FULL);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= EMPTY;
            main_pc_q  <= RESET_PC;
            main_ins_q <= NOP_INS;
            skid_pc_q  <= RESET_PC;
            skid_ins_q <= NOP_INS;
            valid_q    <= 1'b0;
            bubble_q   <= 1'b0;
`ifdef IF_ID_FETCH_EXC_EN
            main_exc_q <= 1'b0;
            skid_exc_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            main_pc_q  <= main_pc_d;
            main_ins_q <= main_ins_d;
            skid_pc_q  <= skid_pc_d;
            skid_ins_q <= skid_ins_d;
            valid_q    <= valid_d;
            bubble_q   <= bubble_d;
`ifdef IF_ID_FETCH_EXC_EN
            main_exc_q <= main_exc_d;
            skid_exc_q <= skid_exc_d;
`endif
        end
    end

    assign id_pc     = main_pc_q;
    assign id_ins    = main_ins_q;
    assign id_valid  = valid_q;
    assign if_bubble = bubble_q;
`ifdef IF_ID_FETCH_EXC_EN
    assign id_exc_adel = main_exc_q;
`endif

endmodule
